// File: rtl/axo_uart_tx_if.sv
// rtl/axo_uart_tx_if.sv - axo memory-bus slave port bundle for the UART transmitter

`ifndef AXO_MEM_EALIGN
`define AXO_MEM_EALIGN 32'h0000_0001
`endif
`ifndef AXO_MEM_EASIZE
`define AXO_MEM_EASIZE 32'h0000_0002
`endif

interface axo_uart_tx_if;
  logic        re;
  logic        we;
  logic [1:0]  asize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        error;

  modport master (output re, we, asize, addr, wdata, input rdata, ready, error);
  modport slave  (input re, we, asize, addr, wdata, output rdata, ready, error);
endinterface

// File: rtl/axo_uart_tx.sv
// rtl/axo_uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and drain interrupt

module axo_uart_tx #(
  parameter int          DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic          clk,
  input  logic          rst_n,
  axo_uart_tx_if.slave  bus,
  output logic          txd,
  output logic          irq
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  state_t      r_state;
  logic [15:0] r_cnt;
  logic [15:0] r_div_q;
  logic [15:0] r_div;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit;
  logic        r_ovf;
  logic        r_irq_en;
  logic        r_txd;
  logic        r_irq;

  logic        w_full;
  logic        w_empty;
  logic        w_req;
  logic        w_ealign;
  logic        w_easize;
  logic        w_ok;
  logic        w_wr;
  logic [1:0]  w_sel;
  logic        w_push_req;
  logic        w_pop;
  logic        w_push;
  logic        w_unused_bits;

  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  // Alignment fault wins over size fault; faulted accesses have no side effect.
  assign w_req    = bus.re | bus.we;
  assign w_ealign = w_req && (bus.addr[1:0] != 2'd0);
  assign w_easize = w_req && !w_ealign && (bus.asize != 2'd2);
  assign w_ok     = w_req && !w_ealign && !w_easize;
  assign w_wr     = w_ok && bus.we;
  assign w_sel    = bus.addr[3:2];

  // A pop in the same cycle frees a slot, so a push while full is still accepted.
  assign w_push_req = w_wr && (w_sel == 2'd0);
  assign w_pop      = (r_state == S_IDLE) && !w_empty;
  assign w_push     = w_push_req && (!w_full || w_pop);

  assign w_unused_bits = ^{bus.addr[31:4], bus.wdata[31:16]};

  assign bus.ready = 1'b1;
  assign bus.error = w_ealign | w_easize;
  assign txd       = r_txd;
  assign irq       = r_irq;

  // Combinational read mux and fault codes.
  always_comb begin
    bus.rdata = 32'd0;
    if (w_ealign) begin
      bus.rdata = `AXO_MEM_EALIGN;
    end else if (w_easize) begin
      bus.rdata = `AXO_MEM_EASIZE;
    end else if (w_ok && bus.re) begin
      case (w_sel)
        2'd1:    bus.rdata = {28'd0, r_ovf, (r_state != S_IDLE), w_empty, w_full};
        2'd2:    bus.rdata = {16'd0, r_div};
        2'd3:    bus.rdata = {31'd0, r_irq_en};
        default: bus.rdata = 32'd0;
      endcase
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= bus.wdata[7:0];
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Control registers: divisor, interrupt enable, sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div    <= DEFAULT_DIV;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr && (w_sel == 2'd2)) r_div    <= bus.wdata[15:0];
      if (w_wr && (w_sel == 2'd3)) r_irq_en <= bus.wdata[0];
      if (w_push_req && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr && (w_sel == 2'd1) && bus.wdata[3]) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Serializer; txd is registered from the current state, so it lags the state by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
      r_div_q <= 16'd0;
      r_shift <= 8'd0;
      r_bit   <= 3'd0;
      r_txd   <= 1'b1;
    end else begin
      case (r_state)
        S_START: r_txd <= 1'b0;
        S_DATA:  r_txd <= r_shift[0];
        default: r_txd <= 1'b1;
      endcase
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift <= r_mem[r_rd_ptr[AW-1:0]];
            r_div_q <= r_div;
            r_cnt   <= 16'd0;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (r_cnt == r_div_q) begin
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (r_cnt == r_div_q) begin
            r_cnt   <= 16'd0;
            r_shift <= {1'b0, r_shift[7:1]};
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          if (r_cnt == r_div_q) begin
            r_cnt   <= 16'd0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
      endcase
    end
  end

  // Drain interrupt: enabled, nothing queued and nothing on the wire.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en && w_empty && (r_state == S_IDLE);
    end
  end

endmodule

// File: tb/tb_axo_uart_tx.sv
// tb/tb_axo_uart_tx.sv - self-checking bench for axo_uart_tx

`ifndef AXO_MEM_EALIGN
`define AXO_MEM_EALIGN 32'h0000_0001
`endif
`ifndef AXO_MEM_EASIZE
`define AXO_MEM_EASIZE 32'h0000_0002
`endif

module tb_axo_uart_tx;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic txd;
  logic irq;

  axo_uart_tx_if bus_if ();

  axo_uart_tx #(.DEPTH(DEPTH), .DEFAULT_DIV(16'd433)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic bus_idle();
    bus_if.re = 1'b0; bus_if.we = 1'b0; bus_if.asize = 2'd2;
    bus_if.addr = 32'd0; bus_if.wdata = 32'd0;
  endtask

  task automatic bus_acc(input logic re, input logic we, input logic [1:0] asize,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic err);
    @(negedge clk);
    bus_if.re = re; bus_if.we = we; bus_if.asize = asize;
    bus_if.addr = addr; bus_if.wdata = wdata;
    #1;
    rd = bus_if.rdata;
    err = bus_if.error;
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, output int edge_n);
    logic [31:0] r;
    logic e;
    bus_acc(1'b0, 1'b1, 2'd2, addr, data, r, e);
    edge_n = cyc;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    logic e;
    bus_acc(1'b1, 1'b0, 2'd2, addr, 32'd0, data, e);
  endtask

  // Line receiver: checks every sample of every bit cell plus one idle-high gap sample.
  bit         rx_en = 1'b0;
  int         rx_p = 1;
  logic [7:0] rx_q[$];
  bit         rx_act = 1'b0;
  bit         rx_ok;
  int         rx_i;
  logic [7:0] rx_byte;

  always @(negedge clk) begin
    int k;
    int o;
    if (!rx_en) begin
      rx_act = 1'b0;
    end else begin
      if (!rx_act && txd === 1'b0) begin
        rx_act = 1'b1; rx_i = 0; rx_ok = 1'b1; rx_byte = 8'd0;
      end
      if (rx_act) begin
        k = rx_i / rx_p;
        o = rx_i % rx_p;
        if (k == 0) begin
          if (txd !== 1'b0) rx_ok = 1'b0;
        end else if (k <= 8) begin
          if (o == 0) rx_byte[k-1] = txd;
          else if (txd !== rx_byte[k-1]) rx_ok = 1'b0;
        end else if (k == 9) begin
          if (txd !== 1'b1) rx_ok = 1'b0;
        end else begin
          if (txd !== 1'b1) rx_ok = 1'b0;
          check("frame_shape", {31'd0, rx_ok}, 32'd1);
          rx_q.push_back(rx_byte);
          rx_act = 1'b0;
        end
        rx_i++;
      end
    end
  end

  // Reference model: pops are spaced one frame (10 bit periods + 1 idle clock) apart.
  int         m_push[$];
  int         m_pop[$];
  logic [7:0] m_bytes[$];
  bit         m_ovf;

  task automatic model_reset();
    m_push.delete(); m_pop.delete(); m_bytes.delete(); m_ovf = 1'b0;
  endtask

  task automatic model_push(input int t, input logic [7:0] b, input int p);
    int occ = 0;
    bit popping = 1'b0;
    int pop_t;
    foreach (m_push[i]) begin
      if (m_push[i] < t && m_pop[i] >= t) occ++;
      if (m_pop[i] == t) popping = 1'b1;
    end
    if (occ < DEPTH || popping) begin
      pop_t = t + 1;
      if (m_pop.size() > 0 && m_pop[$] + 10 * p + 1 > pop_t) pop_t = m_pop[$] + 10 * p + 1;
      m_push.push_back(t); m_pop.push_back(pop_t); m_bytes.push_back(b);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic wait_idle();
    logic [31:0] s;
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rd(32'h4, s);
      if (s[2:0] == 3'b010) begin ok = 1'b1; break; end
    end
    check("drain_timeout", {31'd0, ok}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_traffic(input int n, input int maxgap, input int p);
    int t;
    logic [7:0] b;
    logic [31:0] s;
    model_reset();
    rx_q.delete();
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      wr(32'h0, {24'd0, b}, t);
      model_push(t, b, p);
      if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(posedge clk);
    end
    wait_idle();
    check("rx_count", rx_q.size(), m_bytes.size());
    foreach (m_bytes[i]) begin
      if (i < rx_q.size()) check($sformatf("rx_byte%0d", i), {24'd0, rx_q[i]}, {24'd0, m_bytes[i]});
    end
    rd(32'h4, s);
    check("ovf_flag", {31'd0, s[3]}, {31'd0, m_ovf});
  endtask

  typedef struct {
    logic        re;
    logic        we;
    logic [1:0]  asize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic e;
    int t;
    int m;
    int p;
    int cnt;
    int lows;

    vecs[0]  = '{1'b1, 1'b0, 2'd2, 32'h4, 32'h0,        32'h2,            1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h8, 32'h0,        32'd433,          1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'hC, 32'h0,        32'h0,            1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'h0, 32'h0,        32'h0,            1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'd0, 32'h5, 32'h0,        32'h0,            1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 32'h1, 32'hAB,       `AXO_MEM_EALIGN,  1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'h4, 32'h0,        `AXO_MEM_EASIZE,  1'b1};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 32'h6, 32'h0,        `AXO_MEM_EALIGN,  1'b1};
    vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h4, 32'h0,        32'h2,            1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 32'hC, 32'h1,        `AXO_MEM_EASIZE,  1'b1};
    vecs[10] = '{1'b1, 1'b0, 2'd2, 32'hC, 32'h0,        32'h0,            1'b0};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 32'h8, 32'h12345678, 32'h0,            1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'd2, 32'h8, 32'h0,        32'h5678,         1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd2, 32'h8, 32'h3,        32'h0,            1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'd2, 32'h8, 32'h0,        32'h3,            1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd2, 32'hC, 32'hFFFFFFFE, 32'h0,            1'b0};
    vecs[16] = '{1'b1, 1'b0, 2'd2, 32'hC, 32'h0,        32'h0,            1'b0};

    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_txd", {31'd0, txd}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);

    foreach (vecs[i]) begin
      bus_acc(vecs[i].re, vecs[i].we, vecs[i].asize, vecs[i].addr, vecs[i].wdata, r, e);
      check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rdata);
      check($sformatf("vec%0d_error", i), {31'd0, e}, {31'd0, vecs[i].exp_err});
    end

    // Single byte at DIVISOR=3.
    rx_p = 4;
    rx_en = 1'b1;
    rx_q.delete();
    wr(32'h0, 32'h55, t);
    @(posedge clk); #1;
    check("latency_n1_txd", {31'd0, txd}, 32'd1);
    @(posedge clk); #1;
    check("latency_n2_txd", {31'd0, txd}, 32'd0);
    rd(32'h4, r);
    check("status_busy", r, 32'h6);
    wait_idle();
    rd(32'h4, r);
    check("status_done", r, 32'h2);
    check("single_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("single_byte", {24'd0, rx_q[0]}, 32'h55);

    // Overflow at DIVISOR=0.
    wr(32'h8, 32'h0, t);
    rx_p = 1;
    run_traffic(DEPTH + 2, 0, 1);
    check("ovf_frames", rx_q.size(), DEPTH + 1);
    wr(32'h4, 32'h8, t);
    rd(32'h4, r);
    check("ovf_cleared", r, 32'h2);

    // Randomized traffic against the model.
    for (int k = 0; k < 3; k++) begin
      p = $urandom_range(1, 3);
      wr(32'h8, p - 1, t);
      rx_p = p;
      run_traffic(20, (k == 0) ? 40 : 4, p);
      wr(32'h4, 32'h8, t);
    end

    // Drain interrupt at DIVISOR=0.
    wr(32'h8, 32'h0, t);
    rx_p = 1;
    rx_q.delete();
    wr(32'hC, 32'h1, t);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_rise", {31'd0, irq}, 32'd1);
    wr(32'h0, 32'hA3, m);
    @(posedge clk); #1;
    check("irq_fall", {31'd0, irq}, 32'd0);
    cnt = 0;
    while (!irq && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("irq_reassert_edge", cyc - m, 32'd12);
    repeat (3) @(posedge clk);
    #1;
    check("irq_frame_count", rx_q.size(), 32'd1);
    if (rx_q.size() > 0) check("irq_frame_byte", {24'd0, rx_q[0]}, 32'hA3);
    wr(32'hC, 32'h0, t);

    // Asynchronous reset during data bit 3.
    wr(32'h8, 32'h3, t);
    rx_en = 1'b0;
    wr(32'h0, 32'h00, m);
    wr(32'h0, 32'h00, t);
    cnt = 0;
    while (cyc < m + 19 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    #2;
    check("pre_reset_txd", {31'd0, txd}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_reset_txd", {31'd0, txd}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rd(32'h4, r);
    check("post_reset_status", r, 32'h2);
    rd(32'h8, r);
    check("post_reset_div", r, 32'd433);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (txd !== 1'b1) lows++;
    end
    check("post_reset_quiet", lows, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axo_uart_tx.md
Name: axo_uart_tx

Overview:
- Memory-mapped UART transmitter on an axo memory-bus slave port, downstream of the CPU data port via axo_mem_demux.
- Replaces the simulation-only character sink at address 256 with a synthesizable byte FIFO plus 8N1 serializer.
- Provides an optional level interrupt that fires when the transmitter has fully drained.

Parameters:
- DEPTH, 8: TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd433: reset value of DIVISOR. Bit period is DIVISOR+1 clocks.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- re  input  1  bus read strobe.
- we  input  1  bus write strobe.
- asize  input  2  access size, log2 bytes.
- addr  input  32  byte address; only addr[3:0] is decoded.
- wdata  input  32  write data.
- rdata  output  32  read data.
- ready  output  1  access complete.
- error  output  1  access faulted; rdata then carries the axo error code.
- txd  output  1  serial output; idles high.
- irq  output  1  TX-drained interrupt, level-sensitive.

Behaviour:
- Reset: FIFO empty, serializer IDLE, txd=1, DIVISOR=DEFAULT_DIV, IRQ_EN=0, OVF=0, irq=0.
  - Reset mid-frame aborts the frame immediately; txd returns to 1 asynchronously.
- Bus is single-cycle: ready=1 combinationally. rdata and error are combinational from the current request and register state. Register writes commit on the clk edge of the request cycle.
- Fault rules:
  - addr[1:0]!=0 with re|we: error=1, rdata=`AXO_MEM_EALIGN, no side effect.
  - asize!=2 with re|we: error=1, rdata=`AXO_MEM_EASIZE, no side effect.
  - Alignment takes priority over size.
  - re=we=0: error=0, rdata=0.
- Register map (addr[3:2]):
  - 0 DATA: write pushes wdata[7:0]; reads return 0.
  - 1 STATUS (read-only except OVF):
    - bit0 FULL, bit1 EMPTY, bit2 BUSY (serializer not IDLE), bit3 OVF (sticky).
    - Writing 1 to bit3 clears OVF.
  - 2 DIVISOR: bits[15:0] read/write; upper bits read 0.
  - 3 CTRL: bit0 IRQ_EN, read/write.
- FIFO overflow: a push while FULL drops the byte and sets OVF. No bus error.
- FIFO simultaneous push and pop:
  - When FULL: the pop frees a slot, so the push is accepted and OVF is not set.
  - When EMPTY: the push is stored; the serializer pops it no earlier than the next cycle.
- Serializer FSM. cnt counts bit-period clocks; bit counts data bits 0..7.
  - IDLE: if FIFO non-empty, pop the byte into shift register, latch DIVISOR into div_q, clear cnt, go to START. txd=1.
  - START: txd=0 for div_q+1 clocks, then DATA with bit=0.
  - DATA: txd=shift[0] for div_q+1 clocks, then shift right. After bit 7, go to STOP.
  - STOP: txd=1 for div_q+1 clocks, then IDLE.
  - Back-to-back bytes: IDLE lasts exactly 1 clock between frames.
- Latency: an empty, idle block receiving a DATA write at edge N drives txd low starting at edge N+2.
- DIVISOR changes mid-frame do not affect the current frame; they apply from the next START.
- DIVISOR=0: one clock per bit, which must work.
- txd is registered and glitch-free.
- irq = IRQ_EN & EMPTY & serializer IDLE, registered with one-cycle delay.
- FIFO pointers are log2(DEPTH)+1 bits and wrap naturally.
  - FULL when the MSBs differ and the low bits are equal.
  - EMPTY when the pointers are equal.

Test Plan:
- Reset and read-back: pulse rst_n low, read offsets 4/8/12 -> 0x2, 433, 0; txd=1, irq=0.
- Single byte: write DIVISOR=3, then DATA=0x55 -> txd low at +2 edges; bits 1,0,1,0,1,0,1,0 each held 4 clocks; stop bit high; STATUS goes 0x6 during the frame, then 0x2.
- Overflow: DIVISOR=0, write DEPTH+2 bytes back-to-back without waiting:
  - STATUS.OVF=1.
  - Exactly DEPTH+1 frames are emitted: one popped immediately, DEPTH buffered, the last write dropped.
  - Writing STATUS=0x8 clears OVF.
- Faults: write at addr 0x1 -> error=1, rdata=`AXO_MEM_EALIGN, FIFO unchanged; read with asize=0 at 0x4 -> `AXO_MEM_EASIZE.
- Interrupt:
  - CTRL=1 while idle -> irq=1 one cycle later.
  - Push 0xA3 -> irq falls.
  - irq reasserts one cycle after the STOP bit completes.
- Async reset mid-frame: assert rst_n low during DATA bit 3 -> txd=1 immediately, FIFO empty; after release the block is idle with no residual frame.
